// File: rtl/tt_sweep_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tt_sweep_pkg                                                |
// | Purpose  : Shared types and constants for the truth-table sweep        |
// |            controller: FSM state encoding, default truth-table width   |
// |            and a popcount helper usable by any client of the block.    |
// | Ports    : none (package)                                              |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package tt_sweep_pkg;

   localparam int DEF_N_IN = 4;
   localparam int TT_W     = 2**DEF_N_IN;

   // Explicit 2-bit encoding so state registers have a fixed width.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } tt_state_t;

   // Number of set bits in a truth-table word.
   function automatic int popcount(input logic [TT_W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < TT_W; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

endpackage : tt_sweep_pkg
`default_nettype wire

// File: rtl/tt_sweep_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tt_sweep_ctrl_if                                            |
// | Purpose  : Bundles the harness-facing and gate-facing signals of the   |
// |            sweep controller.                                           |
// | Ports    : start_i, expected_tt_i      harness -> controller           |
// |            busy_o, done_o, captured_tt_o, mismatch_o, fail_count_o,    |
// |            first_fail_idx_o            controller -> harness           |
// |            gate_in_o                   controller -> gate-under-test   |
// |            gate_out_i                  gate-under-test -> controller   |
// |            Modports: slave (controller side), master (environment).    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface tt_sweep_ctrl_if #(
   parameter int N_IN = 4
);
   localparam int W_TT = 2**N_IN;

   logic              start_i;
   logic [W_TT-1:0]   expected_tt_i;
   logic [N_IN-1:0]   gate_in_o;
   logic              gate_out_i;
   logic              busy_o;
   logic              done_o;
   logic [W_TT-1:0]   captured_tt_o;
   logic              mismatch_o;
   logic [N_IN:0]     fail_count_o;
   logic [N_IN-1:0]   first_fail_idx_o;

   modport slave (
      input  start_i,
      input  expected_tt_i,
      input  gate_out_i,
      output gate_in_o,
      output busy_o,
      output done_o,
      output captured_tt_o,
      output mismatch_o,
      output fail_count_o,
      output first_fail_idx_o
   );

   modport master (
      output start_i,
      output expected_tt_i,
      output gate_out_i,
      input  gate_in_o,
      input  busy_o,
      input  done_o,
      input  captured_tt_o,
      input  mismatch_o,
      input  fail_count_o,
      input  first_fail_idx_o
   );

endinterface : tt_sweep_ctrl_if
`default_nettype wire

// File: rtl/tt_sweep_ctrl_settle_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : settle_timer                                                |
// | Purpose  : Loadable down-counter timing the SETTLE phase of each       |
// |            vector. The load value leaves room for the one CAPTURE      |
// |            cycle, so SETTLE plus CAPTURE spans exactly SETTLE cycles.  |
// | Ports    : clk, rst   clock / synchronous active-high reset            |
// |            load_i     reload the counter                               |
// |            dec_i      decrement (ignored at zero)                      |
// |            last_o     counter is at its final count                    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic last_o
);

   // SETTLE-1 cycles in the SETTLE state means counting SETTLE-2 down to 0.
   localparam int LOAD_VAL = (SETTLE > 1) ? SETTLE - 2 : 0;
   localparam int CNT_W    = (SETTLE > 2) ? $clog2(SETTLE - 1) : 1;
   localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(LOAD_VAL);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = C_LOAD;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tt_sweep_ctrl                                               |
// | Purpose  : Drives all 2**N_IN input vectors of a combinational gate in |
// |            ascending order, holds each for SETTLE cycles, samples the  |
// |            gate output into a captured truth table and scores it bit   |
// |            by bit against a latched expected truth table.              |
// | Ports    : clk, rst   clock / synchronous active-high reset            |
// |            bus        tt_sweep_ctrl_if.slave (start, expected table,   |
// |                       gate drive/sense, status and results)            |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tt_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter int N_IN   = DEF_N_IN,
   parameter int SETTLE = 2
) (
   input  logic           clk,
   input  logic           rst,
   tt_sweep_ctrl_if.slave bus
);

   localparam int W_TT = 2**N_IN;

   // With SETTLE=1 the whole vector time is the CAPTURE cycle.
   localparam tt_state_t ENTRY_ST = (SETTLE > 1) ? ST_SETTLE : ST_CAPTURE;

   tt_state_t         state_q, state_d;
   logic [N_IN-1:0]   idx_q,   idx_d;
   logic [W_TT-1:0]   exp_q,   exp_d;
   logic [W_TT-1:0]   cap_q,   cap_d;
   logic              mm_q,    mm_d;
   logic [N_IN:0]     fc_q,    fc_d;
   logic [N_IN-1:0]   ffi_q,   ffi_d;

   logic              timer_load;
   logic              timer_dec;
   logic              timer_last;

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (timer_load),
      .dec_i  (timer_dec),
      .last_o (timer_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         exp_q   <= '0;
         cap_q   <= '0;
         mm_q    <= 1'b0;
         fc_q    <= '0;
         ffi_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exp_q   <= exp_d;
         cap_q   <= cap_d;
         mm_q    <= mm_d;
         fc_q    <= fc_d;
         ffi_q   <= ffi_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      exp_d      = exp_q;
      cap_d      = cap_q;
      mm_d       = mm_q;
      fc_d       = fc_q;
      ffi_d      = ffi_q;
      timer_load = 1'b0;
      timer_dec  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               exp_d      = bus.expected_tt_i;
               cap_d      = '0;
               mm_d       = 1'b0;
               fc_d       = '0;
               ffi_d      = '0;
               idx_d      = '0;
               timer_load = 1'b1;
               state_d    = ENTRY_ST;
            end
         end

         ST_SETTLE: begin
            if (timer_last) begin
               state_d = ST_CAPTURE;
            end else begin
               timer_dec = 1'b1;
            end
         end

         ST_CAPTURE: begin
            cap_d[idx_q] = bus.gate_out_i;
            // Scored one bit at a time; the first miss fixes the index.
            if (bus.gate_out_i != exp_q[idx_q]) begin
               fc_d = fc_q + 1'b1;
               if (!mm_q) begin
                  mm_d  = 1'b1;
                  ffi_d = idx_q;
               end
            end
            // Terminate on the all-ones index so idx never wraps to 0.
            if (idx_q == '1) begin
               state_d = ST_DONE;
            end else begin
               idx_d      = idx_q + 1'b1;
               timer_load = 1'b1;
               state_d    = ENTRY_ST;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // idx doubles as the gate drive, so the last vector persists in IDLE.
   assign bus.gate_in_o        = idx_q;
   assign bus.busy_o           = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
   assign bus.done_o           = (state_q == ST_DONE);
   assign bus.captured_tt_o    = cap_q;
   assign bus.mismatch_o       = mm_q;
   assign bus.fail_count_o     = fc_q;
   assign bus.first_fail_idx_o = ffi_q;

endmodule : tt_sweep_ctrl
`default_nettype wire

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that exhaustively exercises one synthesized 4-input combinational gate netlist: it drives all 16 input vectors in ascending order and waits a programmable settle time per vector. It samples the gate output into a captured truth table and compares against an expected truth-table word. It sits between the design-flow regression harness, which supplies the expected hex truth table such as 0x850E, and the gate-under-test, whose inputs and output it owns during a sweep.

## Interface
- `N_IN`, 4: gate input count; truth-table width is 2**N_IN.
- `SETTLE`, 2: cycles each vector is held before sampling; must be ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: launch pulse; honoured only in IDLE.
- `expected_tt` input 2**N_IN: reference truth table; bit i = expected output for input vector i; latched on accepted start.
- `gate_in` output N_IN: drives gate-under-test inputs; bit k drives gate input k.
- `gate_out` input 1: gate-under-test output.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: one-cycle pulse at sweep completion.
- `captured_tt` output 2**N_IN: sampled truth table; bit i = gate_out observed for vector i.
- `mismatch` output 1: sticky per sweep; captured differs from expected in at least one bit.
- `fail_count` output N_IN+1: number of differing bits, 0..16.
- `first_fail_idx` output N_IN: lowest failing vector index; 0 when no fail.

## Operation
- **States:** IDLE, SETTLE, CAPTURE, DONE.
- **IDLE**
  - busy=0.
  - On `start`: latch `expected_tt`, clear `captured_tt`, `mismatch`, `fail_count` and `first_fail_idx`, set idx=0, load settle counter, go to SETTLE.
- **SETTLE**
  - `gate_in`=idx.
  - Counter decrements each cycle.
  - When the counter reaches its final count, go to CAPTURE. SETTLE plus CAPTURE together occupy exactly `SETTLE` cycles per vector; for SETTLE=1, SETTLE is skipped and the block goes straight to CAPTURE.
- **CAPTURE** (last cycle of each vector)
  - Write `captured_tt[idx]`=`gate_out`.
  - If `gate_out`≠`expected_tt[idx]`: increment `fail_count`. If `mismatch` was 0, also set `mismatch` and set `first_fail_idx`=idx.
  - If idx=15, go to DONE. Otherwise increment idx, reload the counter and go to SETTLE.
- **DONE**
  - `done`=1 for one cycle.
  - Return to IDLE.
- **Hold behaviour**
  - Results hold until the next accepted start.
  - `gate_in` holds the last value (15) in IDLE after a sweep.
- **Counter width:** idx is N_IN bits wide and must not wrap before DONE. The CAPTURE decision uses idx==all-ones, not the carry out.
- `start` is ignored while busy or in DONE; no queuing.
- **Comparison arithmetic:**
  - It uses only the current bit; no full-word compare at the end.
  - `fail_count` saturates naturally at 16 because it is N_IN+1 bits wide.

## Timing
- **Reset values:**
  - state=IDLE
  - `gate_in`=0
  - `busy`=0
  - `done`=0
  - `captured_tt`=0
  - `mismatch`=0
  - `fail_count`=0
  - `first_fail_idx`=0
- **Start acceptance:** start is sampled at edge 0. `busy` and `gate_in`=0 are valid from cycle 1.
- **Per-vector timing:** vector i is driven during cycles 1+i·SETTLE .. (i+1)·SETTLE. `gate_out` is sampled at the edge ending cycle (i+1)·SETTLE.
- **Completion:**
  - `done` is high in cycle 16·SETTLE+1.
  - `busy` is high during cycles 1..16·SETTLE and low in the DONE cycle.
  - Results are valid from the `done` cycle.
- `start` asserted in the same cycle as `done` is ignored; start must be asserted in IDLE.
- **Reset mid-sweep:** `rst` has priority over all transitions. All outputs return to reset values on the next edge, and no `done` pulse is produced.

## Structure
- **Shared package `tt_sweep_pkg`:**
  - state enum `tt_state_t` {IDLE, SETTLE, CAPTURE, DONE}
  - localparam `TT_W`=2**N_IN
  - function `popcount` for bench scoreboard reuse
- **Sub-module `settle_timer`:** loadable down-counter with a `last` flag, parameterized by SETTLE. The FSM and result registers stay in the top module.

## Test plan
- **Matching gate:** behavioural gate implementing 0x850E, expected_tt=0x850E, SETTLE=2, start → done at cycle 33, captured_tt=0x850E, mismatch=0, fail_count=0, first_fail_idx=0.
- **Inverted gate:** gate returns the inverse of 0x850E, expected 0x850E → captured_tt=0x7AF1, mismatch=1, fail_count=16, first_fail_idx=0.
- **Single-bit fault:** gate with bit 9 flipped (0x870E), expected 0x850E → fail_count=1, first_fail_idx=9, mismatch=1.
- **Start while busy:** start re-pulsed at cycles 5 and 20 → ignored, single done at cycle 33; start in cycle 34 accepted, second sweep completes.
- **Reset mid-sweep:** rst at cycle 12 → cycle 13 shows all outputs at reset values, no done pulse; a subsequent sweep yields correct results.
- **SETTLE=1 build:** gate whose output changes only one cycle after its inputs → every vector sampled stale, captured_tt equals the expected table shifted by one index. SETTLE=1 timing check: done at cycle 17, gate_in steps every cycle.
